// File: rtl/issue_ctrl.sv
// Front-end issue sequencer: buffers fetched (pc, inst) pairs in a small FIFO
// and presents one decoder slot per cycle, with a NOP bubble when empty or flushing.
module issue_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    output logic [31:0]                fetch_addr,
    input  logic                       fetch_valid,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_inst,
    output logic                       fetch_ready,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       issue,
    output logic                       hit,
    output logic [31:0]                pc_out,
    output logic [31:0]                inst_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic          push, pop, flush_req;

    assign dbg_state = state;

    // Fetch handshake: an entry transfers only when fetch_valid && fetch_ready in
    // the same cycle; fetch_valid without fetch_ready is dropped and re-presented.
    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        issue       = 1'b0;
        hit         = 1'b0;
        flush_req   = 1'b0;
        pc_out      = 32'h0;
        inst_out    = 32'h0;
        if (count != '0) begin
            pc_out   = mem[rptr][63:32];
            inst_out = mem[rptr][31:0];
        end
        if (rdy) begin
            case (state)
                BOOT: state_nxt = RUN;
                RUN: begin
                    fetch_ready = (count < CW'(DEPTH)) && !redirect;
                    issue       = !stall && !redirect;
                    hit         = issue && (count != '0);
                    if (redirect) begin
                        flush_req = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
                FLUSH: begin
                    // Decoder must be overwritten with a NOP even under stall.
                    issue     = 1'b1;
                    flush_req = redirect;
                    state_nxt = redirect ? FLUSH : RUN;
                end
                default: state_nxt = BOOT;
            endcase
        end
        push = fetch_valid && fetch_ready;
        pop  = hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            rptr       <= '0;
            wptr       <= '0;
            fetch_addr <= RESET_PC;
        end else if (rdy) begin
            if (flush_req) begin
                count      <= '0;
                rptr       <= '0;
                wptr       <= '0;
                fetch_addr <= redirect_pc;
            end else begin
                if (push) begin
                    wptr       <= wptr + 1'b1;
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (pop) begin
                    rptr <= rptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {fetch_pc, fetch_inst};
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy = 1'b1;
    logic [31:0]   fetch_addr;
    logic          fetch_valid = 1'b0;
    logic [31:0]   fetch_pc = 32'h0;
    logic [31:0]   fetch_inst = 32'h0;
    logic          fetch_ready;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          issue;
    logic          hit;
    logic [31:0]   pc_out;
    logic [31:0]   inst_out;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    issue_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst), .fetch_ready(fetch_ready),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .issue(issue), .hit(hit), .pc_out(pc_out), .inst_out(inst_out),
        .count(count), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents as a queue, next fetch address, phase
    // (0 = boot cycle, 1 = running, 2 = flush bubble).
    logic [63:0] exp_q[$];
    logic [31:0] m_fa = 32'h0;
    int          m_phase = 0;
    bit          m_pop, m_push;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'h0, act}, {31'h0, exp});
    endtask

    function automatic logic e_issue();
        if (!rdy) return 1'b0;
        if (m_phase == 1) return !stall && !redirect;
        return m_phase == 2;
    endfunction

    function automatic logic e_hit();
        return e_issue() && (m_phase == 1) && (exp_q.size() != 0);
    endfunction

    function automatic logic e_ready();
        return rdy && (m_phase == 1) && (exp_q.size() < DEPTH) && !redirect;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_fa    = 32'h0;
            m_phase = 0;
        end else if (rdy) begin
            if (redirect && m_phase != 0) begin
                exp_q.delete();
                m_fa    = redirect_pc;
                m_phase = 2;
            end else if (m_phase != 1) begin
                m_phase = 1;
            end else begin
                m_pop  = e_hit();
                m_push = fetch_valid && e_ready();
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) begin
                    exp_q.push_back({fetch_pc, fetch_inst});
                    m_fa = m_fa + 32'd4;
                end
            end
        end
    end

    // Scoreboard compare, once per cycle away from the active edge
    always @(negedge clk) begin
        chk32("count", 32'(count), 32'(exp_q.size()));
        chk32("fetch_addr", fetch_addr, m_fa);
        chk1("fetch_ready", fetch_ready, e_ready());
        chk1("issue", issue, e_issue());
        chk1("hit", hit, e_hit());
        chk32("pc_out", pc_out, (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0);
        chk32("inst_out", inst_out, (exp_q.size() != 0) ? exp_q[0][31:0] : 32'h0);
    end

    // Driver tasks
    task automatic drive(input bit v, input bit s, input bit r,
                         input logic [31:0] rpc, input bit rd = 1'b1);
        @(posedge clk);
        #1;
        rdy         = rd;
        fetch_valid = v;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        fetch_pc    = m_fa;
        fetch_inst  = $urandom;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; rdy = 1'b1; fetch_valid = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0;
        @(posedge clk);
        #1;
        chk32("rst_fetch_addr", fetch_addr, 32'h0);
        chk1("rst_issue", issue, 1'b0);
        chk32("rst_count", 32'(count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h0; fetch_inst = $urandom;
        #1;
        chk1("boot_issue", issue, 1'b0);
        chk1("boot_ready", fetch_ready, 1'b0);
    endtask

    initial begin
        // Push-to-issue latency after reset release
        do_reset();
        drive(1, 0, 0, 0);
        chk1("s1_issue", issue, 1'b1); chk1("s1_hit0", hit, 1'b0);
        chk32("s1_fa0", fetch_addr, 32'h0);
        drive(1, 0, 0, 0);
        chk1("s1_hit1", hit, 1'b1); chk32("s1_pc0", pc_out, 32'h0);
        chk32("s1_fa4", fetch_addr, 32'h4);
        drive(1, 0, 0, 0);
        chk32("s1_pc4", pc_out, 32'h4); chk32("s1_fa8", fetch_addr, 32'h8);
        drive(0, 0, 0, 0);
        chk32("s1_fa12", fetch_addr, 32'hc);

        // Fill under stall, then drain in order
        do_reset();
        repeat (6) drive(1, 1, 0, 0);
        chk32("s2_full", 32'(count), 32'd4); chk1("s2_ready", fetch_ready, 1'b0);
        chk32("s2_fa", fetch_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0);
            chk1("s2_hit", hit, 1'b1);
            chk32("s2_pc", pc_out, 32'(i * 4));
        end
        drive(0, 0, 0, 0);
        chk32("s2_empty", 32'(count), 32'd0); chk1("s2_bubble", hit, 1'b0);
        chk1("s2_issue", issue, 1'b1);

        // Redirect with count=3 under stall, push dropped
        do_reset();
        repeat (3) drive(1, 1, 0, 0);
        drive(1, 1, 1, 32'h100);
        chk1("s3_ready", fetch_ready, 1'b0); chk1("s3_issue", issue, 1'b0);
        chk32("s3_cnt", 32'(count), 32'd3);
        drive(0, 0, 0, 0);
        chk32("s3_flush_cnt", 32'(count), 32'd0); chk32("s3_fa", fetch_addr, 32'h100);
        chk1("s3_flush_issue", issue, 1'b1); chk1("s3_flush_hit", hit, 1'b0);
        drive(0, 0, 0, 0);
        chk1("s3_run_ready", fetch_ready, 1'b1);

        // Back-to-back redirects
        drive(1, 1, 0, 0);
        drive(0, 0, 1, 32'h100);
        chk1("s4_issue0", issue, 1'b0); chk32("s4_cnt", 32'(count), 32'd1);
        drive(0, 1, 1, 32'h200);
        chk1("s4_issue1", issue, 1'b1); chk1("s4_hit1", hit, 1'b0);
        drive(0, 0, 0, 0);
        chk32("s4_fa", fetch_addr, 32'h200); chk1("s4_issue2", issue, 1'b1);
        chk1("s4_hit2", hit, 1'b0); chk1("s4_ready2", fetch_ready, 1'b0);
        drive(0, 0, 0, 0);
        chk1("s4_run", fetch_ready, 1'b1);

        // rdy=0 freeze with count=2
        do_reset();
        repeat (2) drive(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 1'b0);
            chk1("s5_issue", issue, 1'b0); chk1("s5_ready", fetch_ready, 1'b0);
            chk32("s5_cnt", 32'(count), 32'd2); chk32("s5_fa", fetch_addr, 32'h8);
        end
        drive(0, 0, 0, 0, 1'b1);
        chk1("s5_hit", hit, 1'b1); chk32("s5_pc", pc_out, 32'h0);

        // Asynchronous reset between edges with count=3
        do_reset();
        repeat (3) drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        chk32("s6_cnt", 32'(count), 32'd0); chk32("s6_fa", fetch_addr, 32'h0);
        chk1("s6_issue", issue, 1'b0); chk1("s6_ready", fetch_ready, 1'b0);
        chk32("s6_pc", pc_out, 32'h0);

        // Randomized traffic
        do_reset();
        repeat (3000) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0, 32'($urandom_range(0, 1023)) << 2,
                  $urandom_range(0, 9) != 0);
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
